history_stack12: RTL and testbench
==================================

# history_stack12

Last-in/first-out history stack for 12-bit register values, used by the reversible datapath's reverse-execution path. During forward execution, the value a 12-bit register is about to lose on a write is pushed here. During reverse execution, the same values are popped back in strict LIFO order and written into the register. This block is the restore side of the register write path.

## Interface
Parameters:
- DEPTH, 16, number of 12-bit entries; a power of two, minimum 2.
- AW, $clog2(DEPTH), pointer width (derived, do not override).

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- clr  input  1  reset, synchronous and active-high; sampled on the rising edge of clk.
- push  input  1  store push_data on top of the stack this cycle.
- push_data  input  12  value being saved (the register's old contents).
- pop  input  1  remove the top entry this cycle.
- pop_data  output  12  value of the entry removed by the last accepted pop (registered).
- pop_valid  output  1  one-cycle strobe; pop_data is valid while it is high.
- count  output  AW+1  number of entries held, from 0 to DEPTH.
- empty  output  1  high when count == 0 (combinational from count).
- full  output  1  high when count == DEPTH (combinational from count).
- ovf  output  1  sticky: set by a push that was rejected because the stack was full.
- udf  output  1  sticky: set by a pop that was rejected because the stack was empty.

## Operation
- Storage: DEPTH x 12 array plus a stack pointer sp, which equals count. The top entry is at index sp-1.
- Push only (push=1, pop=0):
  - Not full: mem[sp] <= push_data; sp <= sp+1.
  - Full: push is dropped, ovf <= 1, contents unchanged.
- Pop only (pop=1, push=0):
  - Not empty: pop_data <= mem[sp-1]; pop_valid <= 1; sp <= sp-1.
  - Empty: pop is dropped, udf <= 1, pop_valid stays 0, pop_data holds its value.
- Push and pop together:
  - Not empty (this includes full): swap. pop_data <= mem[sp-1]; mem[sp-1] <= push_data; pop_valid <= 1; sp unchanged. ovf is not set even when full.
  - Empty: pass-through. pop_data <= push_data; pop_valid <= 1; sp stays 0; udf is not set.
- Neither push nor pop: state held; pop_valid <= 0.
- ovf and udf stay set until clr.
- Memory contents are never cleared. Only sp and the output registers are reset.
- Reset mid-operation: clr has priority over push and pop in the same cycle. Any entries held are discarded.

## Timing
- Reset values after a clk edge with clr=1: count=0, empty=1, full=0, pop_data=12'h000, pop_valid=0, ovf=0, udf=0.
- Pop latency: 1 cycle. A pop sampled at edge N gives pop_valid=1 and pop_data from edge N onward, for exactly one cycle unless another pop follows.
- Push-to-pop turnaround: 0 cycles. A pop in the cycle after a push returns the pushed value.
- Throughput: one push and/or one pop every cycle, with no stall.
- count, full and empty reflect the state after the most recent edge. No lookahead.
- No ready/backpressure signals. Upstream control must check full and empty; ovf and udf exist for error reporting only.

## Structure
- Shared package (revproc_pkg): DATA_W = 12 and the default HIST_DEPTH = 16, also used by the 12-bit register modules.
- Sub-module history_stack_mem:
  - DEPTH x DATA_W register array, no reset.
  - One synchronous write port and one combinational read port addressed by sp-1.
  - Keeps the array separate so it can be swapped for a vendor RAM later.
- Top level holds sp, the sticky flags and the output registers, about 150–250 lines total.

## Test plan
- Reset and LIFO order: clr, then push 12'h001, 12'h002, 12'h003, then three pops.
  - Expect pop_data 003, 002, 001 on consecutive pop_valid cycles, and count 3, 2, 1, 0 with empty=1 at the end.
- Fill and overflow: with DEPTH=16, push 16 values.
  - Expect full=1 and count=16.
  - Push 12'hABC: ovf=1, count=16, and the next pop returns the 16th value, not ABC.
- Underflow: pop when empty.
  - Expect udf=1, pop_valid=0, pop_data unchanged, count=0.
- Simultaneous push and pop:
  - Stack holds [005]; push 12'h0FF with pop. Expect pop_data=005, count=1, and the next pop returns 0FF.
  - Stack empty; push 12'h123 with pop. Expect pop_data=123, pop_valid=1, count=0, udf=0.
- Reset mid-operation:
  - With count=5, assert clr in the same cycle as push. Expect count=0, ovf=udf=0, pop_valid=0.
  - A following pop sets udf.
- Random reference model: 2000 cycles of random push/pop/clr (clr at about 1%), compared cycle by cycle against a queue model on every output.

Source files
------------

// File: rtl/revproc_pkg.sv
// Shared constants for the reversible datapath.
// DATA_W     : width of the 12-bit architectural registers and their history values.
// HIST_DEPTH : default number of history entries held per register.
package revproc_pkg;
  localparam int unsigned DATA_W     = 12;
  localparam int unsigned HIST_DEPTH = 16;
endpackage

// File: rtl/history_stack_mem.sv
// Storage array for history_stack12. Kept apart from the control so it can be
// replaced by a vendor RAM with the same port shape.
// Ports:
//   clk      : clock, writes on rising edge
//   i_we     : write enable
//   i_waddr  : write address
//   i_wdata  : write data
//   i_raddr  : read address (combinational read)
//   o_rdata  : read data
module history_stack_mem
  import revproc_pkg::*;
#(
  parameter int unsigned DEPTH = HIST_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  // Contents are never reset; only the stack pointer decides what is valid.
  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/history_stack12.sv
// LIFO history stack for 12-bit register values on the reverse-execution path.
// Forward execution pushes the value a register is about to lose; reverse
// execution pops them back in strict LIFO order.
// Ports:
//   clk       : clock
//   clr       : synchronous active-high reset (priority over push/pop)
//   push      : store push_data on top this cycle
//   push_data : value being saved
//   pop       : remove top entry this cycle
//   pop_data  : value removed by the last accepted pop (registered)
//   pop_valid : one-cycle strobe qualifying pop_data
//   count     : number of entries held, 0..DEPTH
//   empty     : count == 0
//   full      : count == DEPTH
//   ovf       : sticky, push rejected while full
//   udf       : sticky, pop rejected while empty
module history_stack12
  import revproc_pkg::*;
#(
  parameter int unsigned DEPTH = HIST_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_valid,
  output logic [AW:0]       count,
  output logic              empty,
  output logic              full,
  output logic              ovf,
  output logic              udf
);

  localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

  logic [AW:0]       r_sp;
  logic [DATA_W-1:0] r_pop_data;
  logic              r_pop_valid;
  logic              r_ovf;
  logic              r_udf;

  logic [AW:0]       w_sp_m1;
  logic [AW-1:0]     w_top_idx;
  logic [DATA_W-1:0] w_top_data;
  logic              w_empty;
  logic              w_full;
  logic              w_we;
  logic [AW-1:0]     w_waddr;

  assign w_empty   = (r_sp == '0);
  assign w_full    = (r_sp == FullCount);
  assign w_sp_m1   = r_sp - 1'b1;
  assign w_top_idx = w_sp_m1[AW-1:0];

  // Push-only writes above the top; push+pop overwrites the top in place (swap).
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_sp[AW-1:0];
    if (!clr && push) begin
      if (pop) begin
        w_we    = !w_empty;
        w_waddr = w_top_idx;
      end else begin
        w_we    = !w_full;
        w_waddr = r_sp[AW-1:0];
      end
    end
  end

  history_stack_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (push_data),
    .i_raddr (w_top_idx),
    .o_rdata (w_top_data)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      r_sp        <= '0;
      r_pop_data  <= '0;
      r_pop_valid <= 1'b0;
      r_ovf       <= 1'b0;
      r_udf       <= 1'b0;
    end else begin
      r_pop_valid <= 1'b0;
      if (push && pop) begin
        r_pop_valid <= 1'b1;
        // Empty stack: value passes straight through, no underflow.
        r_pop_data  <= w_empty ? push_data : w_top_data;
      end else if (push) begin
        if (w_full) begin
          r_ovf <= 1'b1;
        end else begin
          r_sp <= r_sp + 1'b1;
        end
      end else if (pop) begin
        if (w_empty) begin
          r_udf <= 1'b1;
        end else begin
          r_pop_data  <= w_top_data;
          r_pop_valid <= 1'b1;
          r_sp        <= w_sp_m1;
        end
      end
    end
  end

  assign pop_data  = r_pop_data;
  assign pop_valid = r_pop_valid;
  assign count     = r_sp;
  assign empty     = w_empty;
  assign full      = w_full;
  assign ovf       = r_ovf;
  assign udf       = r_udf;

endmodule

// File: tb/tb_history_stack12.sv
// Self-checking bench for history_stack12: directed scenarios plus a random run
// against a queue-based reference model.
module tb_history_stack12;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        push = 1'b0;
  logic [11:0] push_data = '0;
  logic        pop = 1'b0;
  logic [11:0] pop_data;
  logic        pop_valid;
  logic [4:0]  count;
  logic        empty;
  logic        full;
  logic        ovf;
  logic        udf;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [11:0] q[$];
  logic [11:0] m_pd  = '0;
  logic        m_pv  = 1'b0;
  logic        m_ovf = 1'b0;
  logic        m_udf = 1'b0;

  history_stack12 #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .clr       (clr),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .pop_valid (pop_valid),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .ovf       (ovf),
    .udf       (udf)
  );

  always #5 clk = ~clk;

  // Apply one cycle of inputs, advance past the edge, update the model.
  task automatic cycle(input logic c, input logic pu, input logic [11:0] d, input logic po);
    clr = c; push = pu; push_data = d; pop = po;
    @(posedge clk);
    #1;
    if (c) begin
      q.delete(); m_pd = '0; m_pv = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    end else if (pu && po) begin
      m_pv = 1'b1;
      if (q.size() == 0) m_pd = d;
      else begin m_pd = q[q.size()-1]; q[q.size()-1] = d; end
    end else if (pu) begin
      m_pv = 1'b0;
      if (q.size() == DEPTH) m_ovf = 1'b1;
      else q.push_back(d);
    end else if (po) begin
      if (q.size() == 0) begin m_udf = 1'b1; m_pv = 1'b0; end
      else begin m_pd = q.pop_back(); m_pv = 1'b1; end
    end else begin
      m_pv = 1'b0;
    end
    clr = 1'b0; push = 1'b0; pop = 1'b0;
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b0, 12'h000, 1'b0);
    total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", empty); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", full); end
    total++; if (pop_data !== 12'h000) begin bad++; $display("FAIL reset_pop_data got=%h want=000", pop_data); end
    total++; if (pop_valid !== 1'b0) begin bad++; $display("FAIL reset_pop_valid got=%b want=0", pop_valid); end
    total++; if (ovf !== 1'b0 || udf !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b want=00", ovf, udf); end
  endtask

  task automatic test_lifo();
    logic [11:0] exp_d;
    cycle(1'b1, 1'b0, 12'h000, 1'b0);
    for (int i = 1; i <= 3; i++) cycle(1'b0, 1'b1, 12'(i), 1'b0);
    total++; if (count !== 5'd3) begin bad++; $display("FAIL lifo_fill_count got=%0d want=3", count); end
    for (int i = 3; i >= 1; i--) begin
      cycle(1'b0, 1'b0, 12'h000, 1'b1);
      exp_d = 12'(i);
      total++; if (pop_valid !== 1'b1 || pop_data !== exp_d) begin
        bad++; $display("FAIL lifo_pop got=%b/%h want=1/%h", pop_valid, pop_data, exp_d);
      end
      total++; if (count !== 5'(i - 1)) begin bad++; $display("FAIL lifo_count got=%0d want=%0d", count, i - 1); end
    end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL lifo_empty got=%b want=1", empty); end
    cycle(1'b0, 1'b0, 12'h000, 1'b0);
    total++; if (pop_valid !== 1'b0) begin bad++; $display("FAIL lifo_strobe_drop got=%b want=0", pop_valid); end
  endtask

  task automatic test_overflow();
    cycle(1'b1, 1'b0, 12'h000, 1'b0);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 12'(12'h100 + i), 1'b0);
    total++; if (full !== 1'b1 || count !== 5'd16) begin
      bad++; $display("FAIL ovf_fill got=%b/%0d want=1/16", full, count);
    end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b want=0", ovf); end
    cycle(1'b0, 1'b1, 12'hABC, 1'b0);
    total++; if (ovf !== 1'b1 || count !== 5'd16) begin
      bad++; $display("FAIL ovf_set got=%b/%0d want=1/16", ovf, count);
    end
    cycle(1'b0, 1'b0, 12'h000, 1'b1);
    total++; if (pop_data !== 12'h10F) begin bad++; $display("FAIL ovf_top got=%h want=10f", pop_data); end
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", ovf); end
  endtask

  task automatic test_underflow();
    cycle(1'b1, 1'b0, 12'h000, 1'b0);
    cycle(1'b0, 1'b1, 12'h777, 1'b0);
    cycle(1'b0, 1'b0, 12'h000, 1'b1);
    cycle(1'b0, 1'b0, 12'h000, 1'b1);
    total++; if (udf !== 1'b1) begin bad++; $display("FAIL udf_set got=%b want=1", udf); end
    total++; if (pop_valid !== 1'b0) begin bad++; $display("FAIL udf_valid got=%b want=0", pop_valid); end
    total++; if (pop_data !== 12'h777) begin bad++; $display("FAIL udf_hold got=%h want=777", pop_data); end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL udf_count got=%0d want=0", count); end
  endtask

  task automatic test_simultaneous();
    cycle(1'b1, 1'b0, 12'h000, 1'b0);
    cycle(1'b0, 1'b1, 12'h005, 1'b0);
    cycle(1'b0, 1'b1, 12'h0FF, 1'b1);
    total++; if (pop_data !== 12'h005 || pop_valid !== 1'b1) begin
      bad++; $display("FAIL swap_data got=%h/%b want=005/1", pop_data, pop_valid);
    end
    total++; if (count !== 5'd1) begin bad++; $display("FAIL swap_count got=%0d want=1", count); end
    cycle(1'b0, 1'b0, 12'h000, 1'b1);
    total++; if (pop_data !== 12'h0FF) begin bad++; $display("FAIL swap_next got=%h want=0ff", pop_data); end
    cycle(1'b0, 1'b1, 12'h123, 1'b1);
    total++; if (pop_data !== 12'h123 || pop_valid !== 1'b1) begin
      bad++; $display("FAIL pass_data got=%h/%b want=123/1", pop_data, pop_valid);
    end
    total++; if (count !== 5'd0 || udf !== 1'b0) begin
      bad++; $display("FAIL pass_state got=%0d/%b want=0/0", count, udf);
    end
    // Swap while full must not flag overflow.
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 12'(12'h200 + i), 1'b0);
    cycle(1'b0, 1'b1, 12'h3C3, 1'b1);
    total++; if (pop_data !== 12'h20F || ovf !== 1'b0 || count !== 5'd16) begin
      bad++; $display("FAIL full_swap got=%h/%b/%0d want=20f/0/16", pop_data, ovf, count);
    end
    cycle(1'b0, 1'b0, 12'h000, 1'b1);
    total++; if (pop_data !== 12'h3C3) begin bad++; $display("FAIL full_swap_next got=%h want=3c3", pop_data); end
  endtask

  task automatic test_clr_mid();
    cycle(1'b1, 1'b0, 12'h000, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 12'(12'h050 + i), 1'b0);
    cycle(1'b0, 1'b0, 12'h000, 1'b1);
    cycle(1'b0, 1'b1, 12'h055, 1'b0);
    total++; if (count !== 5'd5) begin bad++; $display("FAIL clr_pre_count got=%0d want=5", count); end
    cycle(1'b1, 1'b1, 12'hEEE, 1'b0);
    total++; if (count !== 5'd0 || ovf !== 1'b0 || udf !== 1'b0 || pop_valid !== 1'b0) begin
      bad++; $display("FAIL clr_mid got=%0d/%b/%b/%b want=0/0/0/0", count, ovf, udf, pop_valid);
    end
    cycle(1'b0, 1'b0, 12'h000, 1'b1);
    total++; if (udf !== 1'b1) begin bad++; $display("FAIL clr_then_pop got=%b want=1", udf); end
  endtask

  task automatic test_random();
    int push_bias;
    cycle(1'b1, 1'b0, 12'h000, 1'b0);
    for (int n = 0; n < 2000; n++) begin
      // Phase-varying bias so both full and empty regions are exercised.
      push_bias = ((n / 200) % 2 == 0) ? 70 : 30;
      cycle(($urandom_range(99) == 0),
            ($urandom_range(99) < push_bias),
            12'($urandom),
            ($urandom_range(99) < 100 - push_bias));
      total++; if (count !== 5'(q.size())) begin bad++; $display("FAIL rnd_count n=%0d got=%0d want=%0d", n, count, q.size()); end
      total++; if (empty !== (q.size() == 0)) begin bad++; $display("FAIL rnd_empty n=%0d got=%b", n, empty); end
      total++; if (full !== (q.size() == DEPTH)) begin bad++; $display("FAIL rnd_full n=%0d got=%b", n, full); end
      total++; if (pop_valid !== m_pv) begin bad++; $display("FAIL rnd_valid n=%0d got=%b want=%b", n, pop_valid, m_pv); end
      total++; if (pop_data !== m_pd) begin bad++; $display("FAIL rnd_data n=%0d got=%h want=%h", n, pop_data, m_pd); end
      total++; if (ovf !== m_ovf) begin bad++; $display("FAIL rnd_ovf n=%0d got=%b want=%b", n, ovf, m_ovf); end
      total++; if (udf !== m_udf) begin bad++; $display("FAIL rnd_udf n=%0d got=%b want=%b", n, udf, m_udf); end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_lifo();
    test_overflow();
    test_underflow();
    test_simultaneous();
    test_clr_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
